cp0_exc_unit: RTL and testbench

- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline.
- Sits at the M stage. It consumes the exception code, branch-delay flag and PC carried by the M-stage pipeline register.
- It produces the global flush request `req` back to all pipeline registers. On `req`, those registers load PC 0x0000_4180 and zero all other fields.
- Also services mfc0/mtc0/eret and holds SR, Cause and EPC.

---
 rtl/cp0_pkg.sv | 34 +++
 rtl/cp0_timer.sv | 38 +++
 rtl/cp0_exc_unit.sv | 105 ++++++++++
 tb/tb_cp0_exc_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, field positions, defaults.
// No logic of its own; imported by cp0_exc_unit and cp0_timer.
package cp0_pkg;

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam int SR_IM_HI     = 15;
  localparam int SR_IM_LO     = 10;
  localparam int SR_EXL       = 1;
  localparam int SR_IE        = 0;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PRID_DEFAULT       = 32'h2023_0007;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count free-runs, pending raised on Count==Compare (Compare!=0).
// Pending is visible the same cycle as the match and stays set until Compare is rewritten.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_pend
);

  logic pend_q;
  logic hit;

  assign hit        = (count == compare) && (compare != 32'd0);
  assign timer_pend = pend_q | hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 32'd0;
      compare <= 32'd0;
      pend_q  <= 1'b0;
    end else begin
      count <= we_count ? din : count + 32'd1;
      if (we_compare) begin
        compare <= din;
        pend_q  <= 1'b0;
      end else if (hit) begin
        pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt controller at M: combinational req, state updates at next edge.
// Optional Count/Compare timer enabled by `define CP0_TIMER_EN (replaces hwint[5] as IP[15]).
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
  parameter logic [31:0] PRID_VALUE = PRID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_din,
  input  logic [31:0] vpc,
  input  logic        bd,
  input  logic [4:0]  exccode_in,
  input  logic [5:0]  hwint,
  input  logic        eret,
  output logic        req,
  output logic [31:0] cp0_dout,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  logic [5:0]  im, ip, ip_next;
  logic        exl, ie, cause_bd;
  logic [4:0]  exccode;
  logic [31:0] epc;
  logic        int_req, exc_req, wr_en;

  // A flush or eret in the same cycle squashes the mtc0.
  assign wr_en = cp0_we & ~req & ~eret;

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;
  logic        timer_pend;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .we_count   (wr_en && (cp0_addr == ADDR_COUNT)),
    .we_compare (wr_en && (cp0_addr == ADDR_COMPARE)),
    .din        (cp0_din),
    .count      (count),
    .compare    (compare),
    .timer_pend (timer_pend)
  );

  assign ip_next = {timer_pend, hwint[4:0]};
`else
  assign ip_next = hwint;
`endif

  assign int_req    = ie & ~exl & (|(ip_next & im));
  assign exc_req    = (exccode_in != 5'd0) & ~exl;
  assign req        = int_req | exc_req;
  assign epc_out    = epc;
  assign handler_pc = HANDLER_PC;

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      ip       <= 6'd0;
      cause_bd <= 1'b0;
      exccode  <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= ip_next;
      if (req) begin
        exl      <= 1'b1;
        cause_bd <= bd;
        exccode  <= int_req ? 5'(EXC_INT) : exccode_in;
        epc      <= (bd ? vpc - 32'd4 : vpc) & ~32'h3;
      end else if (eret) begin
        exl <= 1'b0;
      end else if (wr_en) begin
        if (cp0_addr == ADDR_SR) begin
          im  <= cp0_din[SR_IM_HI:SR_IM_LO];
          exl <= cp0_din[SR_EXL];
          ie  <= cp0_din[SR_IE];
        end else if (cp0_addr == ADDR_EPC) begin
          epc <= cp0_din;
        end
      end
    end
  end

  always_comb begin
    cp0_dout = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_dout = {16'd0, im, 8'd0, exl, ie};
      ADDR_CAUSE: cp0_dout = {cause_bd, 15'd0, ip, 3'd0, exccode, 2'd0};
      ADDR_EPC:   cp0_dout = epc;
      ADDR_PRID:  cp0_dout = PRID_VALUE;
`ifdef CP0_TIMER_EN
      ADDR_COUNT:   cp0_dout = count;
      ADDR_COMPARE: cp0_dout = compare;
`endif
      default:    cp0_dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed-vector bench for cp0_exc_unit; timer vectors only when CP0_TIMER_EN is defined.
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_din;
  logic [31:0] vpc;
  logic        bd;
  logic [4:0]  exccode_in;
  logic [5:0]  hwint;
  logic        eret;
  logic        req;
  logic [31:0] cp0_dout;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] PRID = 32'h2023_0007;

  cp0_exc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .cp0_we     (cp0_we),
    .cp0_addr   (cp0_addr),
    .cp0_din    (cp0_din),
    .vpc        (vpc),
    .bd         (bd),
    .exccode_in (exccode_in),
    .hwint      (hwint),
    .eret       (eret),
    .req        (req),
    .cp0_dout   (cp0_dout),
    .epc_out    (epc_out),
    .handler_pc (handler_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    check(tag, cp0_dout, exp);
  endtask

  task automatic chk_req(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, req}, {31'd0, exp});
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cp0_addr = a;
    cp0_din  = d;
    cp0_we   = 1'b1;
    tick();
    cp0_we   = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cp0_we = 1'b0; cp0_addr = 5'd0; cp0_din = 32'd0;
    vpc = 32'd0; bd = 1'b0; exccode_in = 5'd0; hwint = 6'h3F; eret = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_epc", 5'd14, 32'd0);
    chk_req("rst_req", 1'b0);
    rd("prid", 5'd15, PRID);
    check("handler_pc", handler_pc, 32'h0000_4180);
    hwint = 6'd0;

    // mtc0 SR: old value visible during the write cycle
    cp0_addr = 5'd12; cp0_din = 32'h0000_FC01; cp0_we = 1'b1;
    #1 check("sr_old", cp0_dout, 32'd0);
    tick();
    cp0_we = 1'b0;
    rd("sr_new", 5'd12, 32'h0000_FC01);

    hwint = 6'b000100; vpc = 32'h1000_0040;
    chk_req("int_req", 1'b1);
    tick();
    hwint = 6'd0;
    rd("int_cause", 5'd13, 32'h0000_1000);
    rd("int_exl", 5'd12, 32'h0000_FC03);
    rd("int_epc", 5'd14, 32'h1000_0040);
    check("epc_out", epc_out, 32'h1000_0040);

    eret = 1'b1;
    chk_req("eret_noreq", 1'b0);
    tick();
    eret = 1'b0;
    rd("eret_exl", 5'd12, 32'h0000_FC01);

    // Overflow in a delay slot with a concurrent mtc0 EPC
    exccode_in = 5'd12; bd = 1'b1; vpc = 32'h0000_3010;
    cp0_addr = 5'd14; cp0_din = 32'hDEAD_BEEF; cp0_we = 1'b1;
    chk_req("ov_req", 1'b1);
    tick();
    cp0_we = 1'b0; exccode_in = 5'd0; bd = 1'b0;
    rd("ov_epc", 5'd14, 32'h0000_300C);
    rd("ov_cause", 5'd13, 32'h8000_0030);

    exccode_in = 5'd10;
    chk_req("exl_mask", 1'b0);
    tick();
    exccode_in = 5'd0;
    rd("mask_cause", 5'd13, 32'h8000_0030);
    rd("mask_epc", 5'd14, 32'h0000_300C);

    do_eret();
    exccode_in = 5'd10; vpc = 32'h0000_2000;
    chk_req("ri_req", 1'b1);
    tick();
    exccode_in = 5'd0;
    rd("ri_cause", 5'd13, 32'h0000_0028);
    rd("ri_epc", 5'd14, 32'h0000_2000);

    do_eret();
    hwint = 6'b000001; exccode_in = 5'd4; vpc = 32'h0000_0500;
    chk_req("both_req", 1'b1);
    tick();
    hwint = 6'd0; exccode_in = 5'd0;
    rd("both_cause", 5'd13, 32'h0000_0400);
    rd("both_epc", 5'd14, 32'h0000_0500);

    do_eret();
    exccode_in = 5'd8; bd = 1'b1; vpc = 32'h0000_0002;
    tick();
    exccode_in = 5'd0; bd = 1'b0;
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0020);

    do_eret();
    wr(5'd13, 32'hFFFF_FFFF);
    rd("cause_ro", 5'd13, 32'h8000_0020);
    wr(5'd15, 32'd0);
    rd("prid_ro", 5'd15, PRID);
    wr(5'd20, 32'h1234_5678);
    rd("unimpl", 5'd20, 32'd0);
    wr(5'd14, 32'h1234_5678);
    rd("epc_wr", 5'd14, 32'h1234_5678);
`ifndef CP0_TIMER_EN
    wr(5'd9, 32'd5);
    rd("no_count", 5'd9, 32'd0);
    wr(5'd11, 32'd5);
    rd("no_compare", 5'd11, 32'd0);
`endif

    exccode_in = 5'd12;
    tick();
    exccode_in = 5'd0;
    rd("pre_rst_exl", 5'd12, 32'h0000_FC03);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd("rst_mid_sr", 5'd12, 32'd0);
    rd("rst_mid_epc", 5'd14, 32'd0);

`ifdef CP0_TIMER_EN
    wr(5'd9, 32'd0);
    wr(5'd11, 32'd5);
    wr(5'd12, 32'h0000_8001);
    for (int k = 2; k <= 5; k++) begin
      rd("tmr_cnt", 5'd9, 32'(k));
      chk_req("tmr_req", k == 5);
      tick();
    end
    rd("tmr_ip", 5'd13, 32'h0000_8000);
    wr(5'd11, 32'd0);
    tick();
    rd("tmr_clr", 5'd13, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
